// File: rtl/pipe_ir_chain.sv
// Instruction-register chain for the 5-stage pipeline.
// Holds the instruction word at each stage boundary (IR1..IR4). It applies
// the control FSM's load / NOOP-select controls, detects read-after-write
// hazards between ir2 and the writing instructions in ir3/ir4, and raises a
// stall. It also keeps a saturating stall counter and a wrapping retired
// instruction counter.
module pipe_ir_chain #(
    parameter logic [7:0] NOP_WORD    = 8'h0A,
    parameter int         STALL_CNT_W = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [7:0]             instr_in,
    input  logic                   S1Load,
    input  logic                   S2Load,
    input  logic                   S3Load,
    input  logic                   WBIRLoad,
    input  logic                   NOOPSel1,
    input  logic                   NOOPSel2,
    input  logic                   NOOPSel3,
    input  logic                   NOOPSel4,
    output logic [7:0]             ir1,
    output logic [7:0]             ir2,
    output logic [7:0]             ir3,
    output logic [7:0]             ir4,
    output logic [3:0]             Dinstr,
    output logic [3:0]             RFinstr,
    output logic [3:0]             Xinstr,
    output logic [3:0]             WBinstr,
    output logic                   stall,
    output logic [STALL_CNT_W-1:0] stall_count,
    output logic [15:0]            retired_count
);

    localparam logic [3:0]             OP_NOP    = 4'b1010;
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;
    localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Instruction field decode helpers
    // ------------------------------------------------------------------

    // True when the instruction writes the register file.
    function automatic logic dest_valid(input logic [7:0] w);
        logic v;
        case (w[3:0])
            4'b0000, 4'b0100, 4'b0110, 4'b1000: v = 1'b1;
            default: v = (w[2:0] == 3'b011) || (w[2:0] == 3'b111);
        endcase
        return v;
    endfunction

    // Destination register: ori always targets r1, everything else RA.
    function automatic logic [1:0] dest_reg(input logic [7:0] w);
        logic [1:0] r;
        if (w[2:0] == 3'b111) begin
            r = 2'b01;
        end else begin
            r = w[7:6];
        end
        return r;
    endfunction

    // True when the instruction reads its first source (RA, or r1 for ori).
    function automatic logic src_a_valid(input logic [7:0] w);
        logic v;
        case (w[3:0])
            4'b0000, 4'b0010, 4'b0100, 4'b0110, 4'b1000: v = 1'b1;
            default: v = (w[2:0] == 3'b011) || (w[2:0] == 3'b111);
        endcase
        return v;
    endfunction

    // First source register number.
    function automatic logic [1:0] src_a_reg(input logic [7:0] w);
        logic [1:0] r;
        if (w[2:0] == 3'b111) begin
            r = 2'b01;
        end else begin
            r = w[7:6];
        end
        return r;
    endfunction

    // True when the instruction also reads RB (two-operand forms only).
    function automatic logic src_b_valid(input logic [7:0] w);
        logic v;
        case (w[3:0])
            4'b0000, 4'b0010, 4'b0100, 4'b0110, 4'b1000: v = 1'b1;
            default: v = 1'b0;
        endcase
        return v;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]             ir1_q, ir1_d;
    logic [7:0]             ir2_q, ir2_d;
    logic [7:0]             ir3_q, ir3_d;
    logic [7:0]             ir4_q, ir4_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [15:0]            retired_cnt_q, retired_cnt_d;

    logic       d3_v_s, d4_v_s;
    logic [1:0] d3_r_s, d4_r_s;
    logic       sa_v_s, sb_v_s;
    logic [1:0] sa_r_s, sb_r_s;
    logic       hit_a_s, hit_b_s;
    logic       raw_s;
    logic       stall_s;
    logic [7:0] ir4_in_s;

    // Hazard detection: ir2 sources against writing ir3/ir4; a flush of
    // IR2 or IR3 removes the offending pair so it overrides the stall.
    always_comb begin
        d3_v_s  = dest_valid(ir3_q);
        d4_v_s  = dest_valid(ir4_q);
        d3_r_s  = dest_reg(ir3_q);
        d4_r_s  = dest_reg(ir4_q);
        sa_v_s  = src_a_valid(ir2_q);
        sb_v_s  = src_b_valid(ir2_q);
        sa_r_s  = src_a_reg(ir2_q);
        sb_r_s  = ir2_q[5:4];
        hit_a_s = sa_v_s && ((d3_v_s && (sa_r_s == d3_r_s)) ||
                             (d4_v_s && (sa_r_s == d4_r_s)));
        hit_b_s = sb_v_s && ((d3_v_s && (sb_r_s == d3_r_s)) ||
                             (d4_v_s && (sb_r_s == d4_r_s)));
        raw_s   = hit_a_s || hit_b_s;
        stall_s = raw_s && !NOOPSel2 && !NOOPSel3;
    end

    // Next-state for the IR chain: a stall freezes IR1/IR2 and injects a
    // bubble into IR3; IR4 is never affected by the stall.
    always_comb begin
        ir1_d    = ir1_q;
        ir2_d    = ir2_q;
        ir3_d    = ir3_q;
        ir4_d    = ir4_q;
        ir4_in_s = NOOPSel4 ? NOP_WORD : ir3_q;

        if (S1Load && !stall_s) begin
            ir1_d = NOOPSel1 ? NOP_WORD : instr_in;
        end else begin
            ir1_d = ir1_q;
        end

        if (S2Load && !stall_s) begin
            ir2_d = NOOPSel2 ? NOP_WORD : ir1_q;
        end else begin
            ir2_d = ir2_q;
        end

        if (S3Load) begin
            ir3_d = (NOOPSel3 || stall_s) ? NOP_WORD : ir2_q;
        end else begin
            ir3_d = ir3_q;
        end

        if (WBIRLoad) begin
            ir4_d = ir4_in_s;
        end else begin
            ir4_d = ir4_q;
        end
    end

    // Next-state for the statistics counters.
    always_comb begin
        stall_cnt_d   = stall_cnt_q;
        retired_cnt_d = retired_cnt_q;

        if (stall_s && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + STALL_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end

        if (WBIRLoad && (ir4_in_s[3:0] != OP_NOP)) begin
            retired_cnt_d = retired_cnt_q + 16'd1;
        end else begin
            retired_cnt_d = retired_cnt_q;
        end
    end

    // State registers; reset fills the chain with bubbles and clears counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ir1_q         <= NOP_WORD;
            ir2_q         <= NOP_WORD;
            ir3_q         <= NOP_WORD;
            ir4_q         <= NOP_WORD;
            stall_cnt_q   <= '0;
            retired_cnt_q <= 16'd0;
        end else begin
            ir1_q         <= ir1_d;
            ir2_q         <= ir2_d;
            ir3_q         <= ir3_d;
            ir4_q         <= ir4_d;
            stall_cnt_q   <= stall_cnt_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign ir1           = ir1_q;
    assign ir2           = ir2_q;
    assign ir3           = ir3_q;
    assign ir4           = ir4_q;
    assign Dinstr        = ir1_q[3:0];
    assign RFinstr       = ir2_q[3:0];
    assign Xinstr        = ir3_q[3:0];
    assign WBinstr       = ir4_q[3:0];
    assign stall         = stall_s;
    assign stall_count   = stall_cnt_q;
    assign retired_count = retired_cnt_q;

endmodule
